// File: rtl/piso_serializer.sv
// Parallel-in, serial-out shift register: accepts a WIDTH-bit word on a valid/ready
// handshake and streams it MSB-first with a true/complement pair and framing strobes.
module piso_serializer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_n,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sout_q, sout_d;
  logic             sout_n_q, sout_n_d;
  logic             sout_valid_q, sout_valid_d;
  logic             frame_start_q, frame_start_d;

  logic             last_bit_s;
  logic             load_ready_s;
  logic             accept_s;

  // Ready while idle or while the final bit of a word is on the line, so words stream gap-free.
  always_comb begin
    last_bit_s   = (state_q == ST_SHIFT) && (cnt_q == CNT_ZERO);
    load_ready_s = !rst && ((state_q == ST_IDLE) || last_bit_s);
    accept_s     = load_valid && load_ready_s;
  end

  // Next-state and output computation for the shift engine.
  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    cnt_d         = cnt_q;
    sout_d        = sout_q;
    sout_n_d      = sout_n_q;
    sout_valid_d  = sout_valid_q;
    frame_start_d = frame_start_q;
    if (accept_s) begin
      state_d       = ST_SHIFT;
      sout_d        = load_data[WIDTH-1];
      sout_n_d      = ~load_data[WIDTH-1];
      shreg_d       = {load_data[WIDTH-2:0], 1'b0};
      cnt_d         = CNT_LAST;
      sout_valid_d  = 1'b1;
      frame_start_d = 1'b1;
    end else begin
      case (state_q)
        ST_SHIFT: begin
          if (cnt_q != CNT_ZERO) begin
            sout_d        = shreg_q[WIDTH-1];
            sout_n_d      = ~shreg_q[WIDTH-1];
            shreg_d       = {shreg_q[WIDTH-2:0], 1'b0};
            cnt_d         = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
            sout_valid_d  = 1'b1;
            frame_start_d = 1'b0;
          end else begin
            state_d       = ST_IDLE;
            sout_d        = 1'b0;
            sout_n_d      = 1'b1;
            sout_valid_d  = 1'b0;
            frame_start_d = 1'b0;
          end
        end
        ST_IDLE: begin
          sout_d        = 1'b0;
          sout_n_d      = 1'b1;
          sout_valid_d  = 1'b0;
          frame_start_d = 1'b0;
        end
        default: begin
          state_d       = ST_IDLE;
          shreg_d       = {WIDTH{1'b0}};
          cnt_d         = CNT_ZERO;
          sout_d        = 1'b0;
          sout_n_d      = 1'b1;
          sout_valid_d  = 1'b0;
          frame_start_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      shreg_q       <= {WIDTH{1'b0}};
      cnt_q         <= CNT_ZERO;
      sout_q        <= 1'b0;
      sout_n_q      <= 1'b1;
      sout_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      cnt_q         <= cnt_d;
      sout_q        <= sout_d;
      sout_n_q      <= sout_n_d;
      sout_valid_q  <= sout_valid_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign load_ready  = load_ready_s;
  assign sout        = sout_q;
  assign sout_n      = sout_n_q;
  assign sout_valid  = sout_valid_q;
  assign frame_start = frame_start_q;
  assign busy        = (state_q == ST_SHIFT);

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parallel-in, serial-out shift register: the transmit-side counterpart to the team's serial-in shift register chain (sreg). It accepts a WIDTH-bit word through a valid/ready load handshake and shifts it out MSB-first, one bit per clock. It drives a true/complement serial pair (sout/sout_n) plus framing strobes, so it can feed an sreg chain or an off-block serial link directly. Back-to-back words stream with no idle gap.

Parameters:
WIDTH, 4, word length in bits; legal range WIDTH >= 2.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
load_valid  input  1  load_data is valid this cycle
load_data  input  WIDTH  parallel word to serialize
load_ready  output  1  block can accept a word this cycle (combinational)
sout  output  1  serial data, MSB first (registered)
sout_n  output  1  registered complement of sout
sout_valid  output  1  sout carries a frame bit this cycle
frame_start  output  1  high on the cycle sout carries bit WIDTH-1 of a word
busy  output  1  state == SHIFT

Behaviour:
- Single clock domain; all state updates on posedge clk; rst is sampled only at posedge clk.
- Reset (rst=1 at an edge): state=IDLE, shreg=0, cnt=0, sout=0, sout_n=1, sout_valid=0, frame_start=0.
- While rst=1, load_ready is forced to 0 and load_valid is ignored.
- Registers: shreg[WIDTH-1:0] holds the bits not yet sent. cnt[$clog2(WIDTH)-1:0] holds the number of bits remaining after the bit currently on sout.
- load_ready = !rst && (state==IDLE || (state==SHIFT && cnt==0)).
- Accept event = load_valid && load_ready at a clock edge.
- On accept:
  - sout <= load_data[WIDTH-1], sout_n <= ~load_data[WIDTH-1]
  - shreg <= load_data << 1
  - cnt <= WIDTH-1
  - sout_valid <= 1, frame_start <= 1, state <= SHIFT
- Latency: the MSB appears on sout the cycle after the accept edge. The word occupies exactly WIDTH consecutive cycles.
- SHIFT with cnt != 0:
  - sout <= shreg[WIDTH-1], sout_n <= ~shreg[WIDTH-1]
  - shreg <= shreg << 1, cnt <= cnt-1
  - frame_start <= 0, sout_valid stays 1
- SHIFT with cnt == 0 (last bit on the line):
  - With an accept: next word is loaded as above. No bubble: sout_valid stays 1 and frame_start pulses.
  - Without an accept: state <= IDLE, sout <= 0, sout_n <= 1, sout_valid <= 0, frame_start <= 0.
- IDLE without load_valid: all outputs hold their reset values.
- load_data is sampled only on an accept edge. Changes to load_data at any other time have no effect on the frame in flight.
- load_valid while load_ready=0 (mid-frame): ignored, no stall or error. The source must hold load_valid until load_ready.
- sout_n == ~sout on every cycle after reset, including idle.
- Reset asserted mid-frame: the frame is abandoned. On the next cycle all outputs are at reset values and no residual bits are emitted afterwards.
- Reset and load_valid in the same cycle: reset wins and the word is not accepted.

Test Plan:
1. Assert rst for 2 cycles, then release with load_valid=0 -> sout=0, sout_n=1, sout_valid=0, frame_start=0, busy=0, load_ready=1; all hold for 10 idle cycles.
2. WIDTH=4, one-cycle load of 4'b1011 in IDLE -> over cycles +1..+4, sout=1,0,1,1 and sout_n=0,1,0,0; sout_valid=1 on all four; frame_start=1 only on +1; load_ready=1 only on +4; at +5 sout_valid=0, busy=0.
3. Back-to-back streaming: present 4'hA, then hold load_valid with 4'h5 -> 8 contiguous bits 1,0,1,0,0,1,0,1; sout_valid never drops; frame_start on cycles +1 and +5; the second accept happens at the +4 edge.
4. Mid-frame load attempt: load 4'hC, then drive load_valid with 4'h3 on cycles +1..+2 only -> load_ready=0 on those cycles; output is 1,1,0,0 then idle; 4'h3 is never emitted.
5. Reset mid-frame: load 4'hF, assert rst on cycle +2 -> from +3, sout=0, sout_n=1, sout_valid=0, busy=0; no further 1s on sout.
6. Loopback: drive sout into an sreg chain b input on the same clk; send 4'b1101 -> the sreg q4 stream equals the sout stream delayed by 4 cycles (1,1,0,1), and q0_4 is its complement.
